// File: rtl/ekf_result_streamer.sv
// Double-buffered output stage for fused EKF frames: captures twelve 32-bit
// words on a strobe and streams them over valid/ready, counting dropped frames.
module ekf_result_streamer #(
  parameter int FRAME_ID_W = 8,
  parameter int DROP_W     = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    in_valid,
  input  logic signed [31:0]      Xf0,
  input  logic signed [31:0]      Xf1,
  input  logic signed [31:0]      Xf2,
  input  logic signed [31:0]      Xf3,
  input  logic signed [31:0]      Xf4,
  input  logic signed [31:0]      Xf5,
  input  logic signed [31:0]      Pf0,
  input  logic signed [31:0]      Pf1,
  input  logic signed [31:0]      Pf2,
  input  logic signed [31:0]      Pf3,
  input  logic signed [31:0]      Pf4,
  input  logic signed [31:0]      Pf5,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [31:0]      out_data,
  output logic [3:0]              out_tag,
  output logic                    out_last,
  output logic [FRAME_ID_W-1:0]   out_frame_id,
  output logic                    busy,
  output logic [DROP_W-1:0]       drop_count
);

  localparam int         DATA_W   = 32;
  localparam int         NWORDS   = 12;
  localparam logic [3:0] LAST_IDX = 4'd11;

  typedef enum logic {IDLE, STREAM} state_t;

  state_t                    st, st_n;
  logic [3:0]                idx, idx_n;
  logic                      pend_vld, pend_vld_n;
  logic [FRAME_ID_W-1:0]     frame_ctr;
  logic [FRAME_ID_W-1:0]     id_a, id_b;
  logic signed [DATA_W-1:0]  buf_a    [NWORDS];
  logic signed [DATA_W-1:0]  buf_b    [NWORDS];
  logic signed [DATA_W-1:0]  in_words [NWORDS];

  logic                      hs, last_hs;
  logic                      accept, drop;
  logic                      wr_a_in, wr_a_pend, wr_b_in;
  logic signed [DATA_W-1:0]  nxt_word;
  logic [FRAME_ID_W-1:0]     nxt_id;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + DROP_W'(1);
  endfunction

  always_comb begin
    in_words[0]  = Xf0;
    in_words[1]  = Xf1;
    in_words[2]  = Xf2;
    in_words[3]  = Xf3;
    in_words[4]  = Xf4;
    in_words[5]  = Xf5;
    in_words[6]  = Pf0;
    in_words[7]  = Pf1;
    in_words[8]  = Pf2;
    in_words[9]  = Pf3;
    in_words[10] = Pf4;
    in_words[11] = Pf5;
  end

  assign hs      = out_valid & out_ready;
  assign last_hs = hs & (idx == LAST_IDX);

  // Next-state: a last-word handshake frees the active slot in the same cycle,
  // so a coincident capture is accepted rather than dropped.
  always_comb begin
    st_n       = st;
    idx_n      = idx;
    pend_vld_n = pend_vld;
    accept     = 1'b0;
    drop       = 1'b0;
    wr_a_in    = 1'b0;
    wr_a_pend  = 1'b0;
    wr_b_in    = 1'b0;
    if (hs) idx_n = idx + 4'd1;
    case (st)
      IDLE: begin
        if (in_valid) begin
          accept  = 1'b1;
          wr_a_in = 1'b1;
          st_n    = STREAM;
          idx_n   = 4'd0;
        end
      end
      STREAM: begin
        if (last_hs) begin
          idx_n = 4'd0;
          if (pend_vld) begin
            wr_a_pend = 1'b1;
            if (in_valid) begin
              accept  = 1'b1;
              wr_b_in = 1'b1;
            end else begin
              pend_vld_n = 1'b0;
            end
          end else if (in_valid) begin
            accept  = 1'b1;
            wr_a_in = 1'b1;
          end else begin
            st_n = IDLE;
          end
        end else if (in_valid) begin
          if (pend_vld) begin
            drop = 1'b1;
          end else begin
            accept     = 1'b1;
            wr_b_in    = 1'b1;
            pend_vld_n = 1'b1;
          end
        end
      end
      default: st_n = IDLE;
    endcase
  end

  // Word presented next cycle, taken from whichever source becomes active.
  always_comb begin
    nxt_word = buf_a[idx_n];
    nxt_id   = id_a;
    if (wr_a_in) begin
      nxt_word = in_words[0];
      nxt_id   = frame_ctr;
    end else if (wr_a_pend) begin
      nxt_word = buf_b[0];
      nxt_id   = id_b;
    end
  end

  // Control and registered outputs
  always_ff @(posedge clk) begin
    if (rst) begin
      st           <= IDLE;
      idx          <= 4'd0;
      pend_vld     <= 1'b0;
      frame_ctr    <= '0;
      drop_count   <= '0;
      out_valid    <= 1'b0;
      busy         <= 1'b0;
      out_last     <= 1'b0;
      out_tag      <= 4'd0;
      out_data     <= '0;
      out_frame_id <= '0;
    end else begin
      st        <= st_n;
      idx       <= idx_n;
      pend_vld  <= pend_vld_n;
      if (accept) frame_ctr <= frame_ctr + FRAME_ID_W'(1);
      if (drop) drop_count <= sat_inc(drop_count);
      out_valid <= (st_n == STREAM);
      busy      <= (st_n == STREAM);
      out_last  <= (st_n == STREAM) && (idx_n == LAST_IDX);
      if (st_n == STREAM) begin
        out_tag      <= idx_n;
        out_data     <= nxt_word;
        out_frame_id <= nxt_id;
      end
    end
  end

  // Frame storage
  always_ff @(posedge clk) begin
    if (wr_a_in) begin
      buf_a <= in_words;
      id_a  <= frame_ctr;
    end else if (wr_a_pend) begin
      buf_a <= buf_b;
      id_a  <= id_b;
    end
    if (wr_b_in) begin
      buf_b <= in_words;
      id_b  <= frame_ctr;
    end
  end

endmodule
